// File: rtl/pipe_hazard_unit.sv
// Hazard detection and stall/flush control for the 5-stage MIPS pipeline.
// Covers the hazards bypassing cannot resolve, and owns the MULT/DIV HI/LO occupancy FSM.
module pipe_hazard_unit #(
  parameter int unsigned MULT_LAT = 4,
  parameter int unsigned DIV_LAT  = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  IF_ID_Rs,
  input  logic [4:0]  IF_ID_Rt,
  input  logic        ID_uses_Rt,
  input  logic        ID_Branch,
  input  logic        ID_HiLo,
  input  logic [4:0]  ID_EX_Rdest,
  input  logic        ID_EX_RegWrite,
  input  logic        ID_EX_MemRead,
  input  logic        ID_EX_MultDiv,
  input  logic        ID_EX_IsDiv,
  input  logic [4:0]  EX_MEM_Rdest,
  input  logic        EX_MEM_MemRead,
  input  logic        EX_MEM_MemAccess,
  input  logic        instr_waitrequest,
  input  logic        data_waitrequest,
  output logic        PC_En,
  output logic        IF_ID_En,
  output logic        IF_ID_Bubble,
  output logic        ID_EX_En,
  output logic        ID_EX_Bubble,
  output logic        EX_MEM_En,
  output logic        MEM_WB_Bubble,
  output logic        MultDiv_Busy,
  output logic        MultDiv_Done,
  output logic [31:0] Stall_Count
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_t;

  // The start edge and the DONE cycle each account for one cycle of occupancy.
  localparam logic [5:0] MULT_LOAD = 6'(MULT_LAT - 2);
  localparam logic [5:0] DIV_LOAD  = 6'(DIV_LAT - 2);

  md_state_t  state;
  logic [5:0] cnt;

  logic mem_freeze;
  logic ex_hit;
  logic mem_hit;
  logic decode_stall;
  logic fetch_stall;

  always_comb begin
    mem_freeze   = data_waitrequest && EX_MEM_MemAccess;
    ex_hit       = (ID_EX_Rdest != 5'd0) &&
                   ((ID_EX_Rdest == IF_ID_Rs) || (ID_uses_Rt && (ID_EX_Rdest == IF_ID_Rt)));
    mem_hit      = (EX_MEM_Rdest != 5'd0) &&
                   ((EX_MEM_Rdest == IF_ID_Rs) || (ID_uses_Rt && (EX_MEM_Rdest == IF_ID_Rt)));
    decode_stall = !mem_freeze &&
                   ((ID_EX_MemRead && ex_hit) ||
                    (ID_Branch && ID_EX_RegWrite && ex_hit) ||
                    (ID_Branch && EX_MEM_MemRead && mem_hit) ||
                    (ID_HiLo && ((state != IDLE) || ID_EX_MultDiv)));
    fetch_stall  = !mem_freeze && !decode_stall && instr_waitrequest;
  end

  always_comb begin
    PC_En         = 1'b1;
    IF_ID_En      = 1'b1;
    IF_ID_Bubble  = 1'b0;
    ID_EX_En      = 1'b1;
    ID_EX_Bubble  = 1'b0;
    EX_MEM_En     = 1'b1;
    MEM_WB_Bubble = 1'b0;
    if (mem_freeze) begin
      PC_En         = 1'b0;
      IF_ID_En      = 1'b0;
      ID_EX_En      = 1'b0;
      EX_MEM_En     = 1'b0;
      MEM_WB_Bubble = 1'b1;
    end else if (decode_stall) begin
      PC_En        = 1'b0;
      IF_ID_En     = 1'b0;
      ID_EX_Bubble = 1'b1;
    end else if (fetch_stall) begin
      PC_En        = 1'b0;
      IF_ID_Bubble = 1'b1;
    end
  end

  assign MultDiv_Busy = (state != IDLE);
  assign MultDiv_Done = (state == DONE);

  // A MULT/DIV frozen in EX waits; once running, the count keeps going through freezes.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ID_EX_MultDiv && EX_MEM_En) begin
            state <= BUSY;
            cnt   <= ID_EX_IsDiv ? DIV_LOAD : MULT_LOAD;
          end
        end
        BUSY: begin
          if (cnt == '0) state <= DONE;
          else           cnt   <= cnt - 6'd1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                         Stall_Count <= '0;
    else if (!PC_En && Stall_Count != '1) Stall_Count <= Stall_Count + 32'd1;
  end

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Self-checking bench for pipe_hazard_unit: vector table, directed multi-cycle
// sequences and randomized traffic against an occupancy-countdown reference model.
module tb_pipe_hazard_unit;

  localparam int unsigned MULT_LAT = 4;
  localparam int unsigned DIV_LAT  = 32;

  // Control vector order: {PC_En, IF_ID_En, IF_ID_Bubble, ID_EX_En, ID_EX_Bubble, EX_MEM_En, MEM_WB_Bubble}
  localparam logic [6:0] C_DEF = 7'b1101010;
  localparam logic [6:0] C_FRZ = 7'b0000001;
  localparam logic [6:0] C_DEC = 7'b0001110;
  localparam logic [6:0] C_FET = 7'b0111010;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       branch;
    logic       hilo;
    logic [4:0] ex_rd;
    logic       ex_rw;
    logic       ex_mr;
    logic       ex_md;
    logic       ex_div;
    logic [4:0] mem_rd;
    logic       mem_mr;
    logic       mem_ma;
    logic       iw;
    logic       dw;
  } in_t;

  typedef struct {
    in_t        i;
    logic [6:0] exp;
  } vec_t;

  localparam in_t Z = '0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  cur = '0;

  logic        PC_En, IF_ID_En, IF_ID_Bubble, ID_EX_En, ID_EX_Bubble, EX_MEM_En, MEM_WB_Bubble;
  logic        MultDiv_Busy, MultDiv_Done;
  logic [31:0] Stall_Count;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .reset_n(rst_n),
    .IF_ID_Rs(cur.rs), .IF_ID_Rt(cur.rt), .ID_uses_Rt(cur.uses_rt),
    .ID_Branch(cur.branch), .ID_HiLo(cur.hilo),
    .ID_EX_Rdest(cur.ex_rd), .ID_EX_RegWrite(cur.ex_rw), .ID_EX_MemRead(cur.ex_mr),
    .ID_EX_MultDiv(cur.ex_md), .ID_EX_IsDiv(cur.ex_div),
    .EX_MEM_Rdest(cur.mem_rd), .EX_MEM_MemRead(cur.mem_mr), .EX_MEM_MemAccess(cur.mem_ma),
    .instr_waitrequest(cur.iw), .data_waitrequest(cur.dw),
    .PC_En(PC_En), .IF_ID_En(IF_ID_En), .IF_ID_Bubble(IF_ID_Bubble),
    .ID_EX_En(ID_EX_En), .ID_EX_Bubble(ID_EX_Bubble), .EX_MEM_En(EX_MEM_En),
    .MEM_WB_Bubble(MEM_WB_Bubble), .MultDiv_Busy(MultDiv_Busy),
    .MultDiv_Done(MultDiv_Done), .Stall_Count(Stall_Count)
  );

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Reference state: cycles of HI/LO occupancy still to come, and the stall tally.
  int unsigned m_left = 0;
  logic [31:0] m_sc = '0;

  logic [6:0]  obs_ctrl;
  logic        obs_busy, obs_done;
  logic [31:0] obs_sc;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_ctrl(input in_t x, input bit busy);
    bit ex_hit, mem_hit, stall;
    if (x.dw && x.mem_ma) return C_FRZ;
    ex_hit  = x.ex_rd != 0 && (x.ex_rd == x.rs || (x.uses_rt && x.ex_rd == x.rt));
    mem_hit = x.mem_rd != 0 && (x.mem_rd == x.rs || (x.uses_rt && x.mem_rd == x.rt));
    stall   = (x.ex_mr && ex_hit) || (x.branch && x.ex_rw && ex_hit) ||
              (x.branch && x.mem_mr && mem_hit) || (x.hilo && (busy || x.ex_md));
    if (stall) return C_DEC;
    if (x.iw)  return C_FET;
    return C_DEF;
  endfunction

  // One clock: drive, compare at the falling edge, advance the model, settle after the rising edge.
  task automatic cycle(input in_t x, input bit use_tab, input logic [6:0] tab, input string nm);
    logic [6:0] e;
    cur = x;
    @(negedge clk);
    obs_ctrl = {PC_En, IF_ID_En, IF_ID_Bubble, ID_EX_En, ID_EX_Bubble, EX_MEM_En, MEM_WB_Bubble};
    obs_busy = MultDiv_Busy;
    obs_done = MultDiv_Done;
    obs_sc   = Stall_Count;
    e = ref_ctrl(x, m_left > 0);
    check("ctrl", {25'd0, obs_ctrl}, {25'd0, e});
    check("busy", {31'd0, obs_busy}, {31'd0, m_left > 0});
    check("done", {31'd0, obs_done}, {31'd0, m_left == 1});
    check("stall_count", obs_sc, m_sc);
    if (use_tab) check(nm, {25'd0, obs_ctrl}, {25'd0, tab});
    if (!rst_n) begin
      m_left = 0;
      m_sc   = '0;
    end else begin
      if (e[6] == 1'b0 && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (m_left > 0) m_left--;
      else if (x.ex_md && !(x.dw && x.mem_ma)) m_left = x.ex_div ? DIV_LAT : MULT_LAT;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic go(input in_t x);
    cycle(x, 1'b0, '0, "");
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    go(Z);
    rst_n = 1'b1;
  endtask

  vec_t tab[17];
  in_t  lu, x;
  int unsigned busy_n, done_at, dones, adv_at;

  initial begin
    lu = '{rs: 5'd5, ex_rd: 5'd5, ex_mr: 1'b1, default: '0};

    tab[0]  = '{Z, C_DEF};
    tab[1]  = '{lu, C_DEC};
    tab[2]  = '{'{rt: 5'd5, uses_rt: 1'b1, ex_rd: 5'd5, ex_mr: 1'b1, default: '0}, C_DEC};
    tab[3]  = '{'{rt: 5'd5, ex_rd: 5'd5, ex_mr: 1'b1, default: '0}, C_DEF};
    tab[4]  = '{'{ex_mr: 1'b1, default: '0}, C_DEF};
    tab[5]  = '{'{rs: 5'd6, ex_rd: 5'd6, ex_rw: 1'b1, default: '0}, C_DEF};
    tab[6]  = '{'{branch: 1'b1, rt: 5'd9, uses_rt: 1'b1, ex_rd: 5'd9, ex_rw: 1'b1, default: '0}, C_DEC};
    tab[7]  = '{'{branch: 1'b1, rs: 5'd3, mem_rd: 5'd3, mem_mr: 1'b1, default: '0}, C_DEC};
    tab[8]  = '{'{branch: 1'b1, mem_mr: 1'b1, default: '0}, C_DEF};
    tab[9]  = '{'{rs: 5'd3, mem_rd: 5'd3, mem_mr: 1'b1, default: '0}, C_DEF};
    tab[10] = '{'{iw: 1'b1, default: '0}, C_FET};
    tab[11] = '{'{rs: 5'd5, ex_rd: 5'd5, ex_mr: 1'b1, dw: 1'b1, mem_ma: 1'b1, default: '0}, C_FRZ};
    tab[12] = '{'{dw: 1'b1, iw: 1'b1, default: '0}, C_FET};
    tab[13] = '{'{mem_ma: 1'b1, default: '0}, C_DEF};
    tab[14] = '{'{rs: 5'd5, ex_rd: 5'd5, ex_mr: 1'b1, iw: 1'b1, default: '0}, C_DEC};
    tab[15] = '{'{hilo: 1'b1, default: '0}, C_DEF};
    tab[16] = '{'{hilo: 1'b1, ex_md: 1'b1, default: '0}, C_DEC};

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset state with all inputs low
    go(Z);
    check("reset_ctrl", {25'd0, obs_ctrl}, {25'd0, C_DEF});
    check("reset_busy", {31'd0, obs_busy}, 32'd0);
    check("reset_done", {31'd0, obs_done}, 32'd0);
    check("reset_sc", obs_sc, 32'd0);

    for (int k = 0; k < 17; k++) cycle(tab[k].i, 1'b1, tab[k].exp, $sformatf("tab%0d", k));

    // Load-use: a single stall cycle
    do_reset();
    go(lu);
    check("lu_stall", {25'd0, obs_ctrl}, {25'd0, C_DEC});
    go(Z);
    check("lu_after", {25'd0, obs_ctrl}, {25'd0, C_DEF});
    check("lu_sc", obs_sc, 32'd1);

    // Branch operand from an ALU op, then from a load
    do_reset();
    go('{branch: 1'b1, rs: 5'd7, ex_rd: 5'd7, ex_rw: 1'b1, default: '0});
    check("br_ex", {25'd0, obs_ctrl}, {25'd0, C_DEC});
    go('{branch: 1'b1, rs: 5'd7, mem_rd: 5'd7, default: '0});
    check("br_mem_alu", {25'd0, obs_ctrl}, {25'd0, C_DEF});
    go('{branch: 1'b1, rs: 5'd7, ex_rd: 5'd7, ex_rw: 1'b1, ex_mr: 1'b1, default: '0});
    check("br_lw_ex", {25'd0, obs_ctrl}, {25'd0, C_DEC});
    go('{branch: 1'b1, rs: 5'd7, mem_rd: 5'd7, mem_mr: 1'b1, mem_ma: 1'b1, default: '0});
    check("br_lw_mem", {25'd0, obs_ctrl}, {25'd0, C_DEC});
    go(Z);
    check("br_sc", obs_sc, 32'd3);

    // DIV occupancy with MFLO waiting in ID
    do_reset();
    go('{hilo: 1'b1, ex_md: 1'b1, ex_div: 1'b1, default: '0});
    check("div_issue", {25'd0, obs_ctrl}, {25'd0, C_DEC});
    busy_n = 0; done_at = 0; dones = 0; adv_at = 0;
    for (int k = 1; k <= 40; k++) begin
      go('{hilo: 1'b1, default: '0});
      if (obs_busy) busy_n++;
      if (obs_done) begin dones++; done_at = busy_n; end
      if (obs_ctrl[6]) begin adv_at = k; break; end
    end
    check("div_busy_cycles", busy_n, DIV_LAT);
    check("div_done_pos", done_at, DIV_LAT);
    check("div_done_pulses", dones, 1);
    check("div_advance", adv_at, DIV_LAT + 1);

    // Memory freeze takes priority over a pending load-use stall
    do_reset();
    x = lu; x.dw = 1'b1; x.mem_ma = 1'b1;
    for (int k = 0; k < 3; k++) begin
      go(x);
      check("freeze", {25'd0, obs_ctrl}, {25'd0, C_FRZ});
    end
    go(lu);
    check("freeze_then_lu", {25'd0, obs_ctrl}, {25'd0, C_DEC});
    go(Z);
    check("freeze_sc", obs_sc, 32'd4);

    // Instruction memory wait states
    do_reset();
    for (int k = 0; k < 2; k++) begin
      go('{iw: 1'b1, default: '0});
      check("fetch", {25'd0, obs_ctrl}, {25'd0, C_FET});
    end
    go(Z);
    check("fetch_sc", obs_sc, 32'd2);

    // MULT abandoned by reset
    do_reset();
    go('{ex_md: 1'b1, default: '0});
    go(Z);
    check("mult_busy", {31'd0, obs_busy}, 32'd1);
    rst_n = 1'b0;
    go(Z);
    rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 5; k++) begin
      go(Z);
      if (k == 0) check("mult_rst_busy", {31'd0, obs_busy}, 32'd0);
      if (obs_done) dones++;
    end
    check("mult_rst_done", dones, 0);
    check("mult_rst_sc", obs_sc, 32'd0);

    // MULT held in EX by a freeze does not start until unfrozen
    do_reset();
    go('{ex_md: 1'b1, dw: 1'b1, mem_ma: 1'b1, default: '0});
    go('{ex_md: 1'b1, dw: 1'b1, mem_ma: 1'b1, default: '0});
    check("frz_md_idle", {31'd0, obs_busy}, 32'd0);
    go('{ex_md: 1'b1, default: '0});
    check("frz_md_still_idle", {31'd0, obs_busy}, 32'd0);
    go(Z);
    check("frz_md_started", {31'd0, obs_busy}, 32'd1);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      x.rs      = 5'($urandom_range(0, 3));
      x.rt      = 5'($urandom_range(0, 3));
      x.uses_rt = 1'($urandom_range(0, 1));
      x.branch  = ($urandom_range(0, 3) == 0);
      x.hilo    = ($urandom_range(0, 3) == 0);
      x.ex_rd   = 5'($urandom_range(0, 3));
      x.ex_rw   = 1'($urandom_range(0, 1));
      x.ex_mr   = ($urandom_range(0, 3) == 0);
      x.ex_md   = ($urandom_range(0, 7) == 0);
      x.ex_div  = ($urandom_range(0, 3) == 0);
      x.mem_rd  = 5'($urandom_range(0, 3));
      x.mem_mr  = ($urandom_range(0, 3) == 0);
      x.mem_ma  = 1'($urandom_range(0, 1));
      x.iw      = ($urandom_range(0, 3) == 0);
      x.dw      = ($urandom_range(0, 3) == 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      go(x);
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
